// File: rtl/fpu_fixed_converter.sv
// Float-to-fixed converter: takes {sign, exp[6] bias 31, mantissa[25]} words and
// produces a saturating signed fixed-point value, shifting one bit per clock.
module fpu_fixed_converter #(
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic             clock100KHz,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      float_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] int_out,
  output logic [3:0]       status_out
);

  // Shift count never exceeds max(25, OUT_W-27) < OUT_W.
  localparam int unsigned CntW = $clog2(OUT_W + 1);
  localparam logic signed [15:0] PMax = 16'(OUT_W - 1);
  localparam logic [OUT_W-1:0] MaxPos = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MinNeg = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StClassify, StShift, StSign, StDone} state_e;
  // Result class decided in CLASSIFY; only KNorm uses the shifted magnitude.
  typedef enum logic [2:0] {KNorm, KZero, KUnder, KOver, KMin} kind_e;

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [31:0]       fin_q, fin_d;
  logic [OUT_W-1:0]  mag_q, mag_d;
  logic              sticky_q, sticky_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              left_q, left_d;
  logic [OUT_W-1:0]  int_out_q, int_out_d;
  logic [3:0]        status_q, status_d;

  logic              sgn;
  logic [5:0]        exp_w;
  logic [25:0]       sig;
  logic signed [15:0] p_s, k_s;

  assign sgn   = fin_q[31];
  assign exp_w = fin_q[30:25];
  assign sig   = {1'b1, fin_q[24:0]};
  // p: bit position of the hidden one in the output; k: shift applied to sig.
  assign p_s   = $signed({10'd0, exp_w}) + $signed(16'(FRAC_BITS)) - 16'sd31;
  assign k_s   = p_s - 16'sd25;

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign int_out    = int_out_q;
  assign status_out = status_q;

  // Next-state, datapath and result computation.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    fin_d     = fin_q;
    mag_d     = mag_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    int_out_d = int_out_q;
    status_d  = status_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          fin_d   = float_in;
          state_d = StClassify;
        end
      end
      StClassify: begin
        mag_d    = OUT_W'(sig);
        sticky_d = 1'b0;
        kind_d   = KNorm;
        state_d  = StSign;
        if (exp_w == 6'd0) begin
          kind_d = KZero;
        end else if (p_s >= PMax) begin
          // Only -2^(OUT_W-1) itself is representable at the top position.
          kind_d = (sgn && fin_q[24:0] == 25'd0 && p_s == PMax) ? KMin : KOver;
        end else if (p_s < 16'sd0) begin
          kind_d = KUnder;
        end else if (k_s != 16'sd0) begin
          left_d  = (k_s > 16'sd0);
          cnt_d   = (k_s > 16'sd0) ? CntW'(k_s) : CntW'(-k_s);
          state_d = StShift;
        end
      end
      StShift: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d    = mag_q >> 1;
          sticky_d = sticky_q | mag_q[0];
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StSign;
      end
      StSign: begin
        unique case (kind_q)
          KZero: begin
            int_out_d = '0;
            status_d  = 4'b0001;
          end
          KUnder: begin
            int_out_d = '0;
            status_d  = 4'b0111;
          end
          KOver: begin
            int_out_d = sgn ? MinNeg : MaxPos;
            status_d  = 4'b1000;
          end
          KMin: begin
            int_out_d = MinNeg;
            status_d  = 4'b0000;
          end
          default: begin
            int_out_d = sgn ? (~mag_q + 1'b1) : mag_q;
            status_d  = {2'b00, sticky_q, (mag_q == '0)};
          end
        endcase
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      kind_q    <= KNorm;
      fin_q     <= '0;
      mag_q     <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      int_out_q <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      fin_q     <= fin_d;
      mag_q     <= mag_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      int_out_q <= int_out_d;
      status_q  <= status_d;
    end
  end

endmodule

// File: tb/tb_fpu_fixed_converter.sv
// Scoreboard bench for fpu_fixed_converter: directed corner cases, random floats,
// backpressure and mid-conversion reset, checked against an arithmetic model.
module tb_fpu_fixed_converter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   float_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  int_out;
  logic [3:0]    status_out;

  logic          in_valid8 = 1'b0;
  logic          in_ready8;
  logic [31:0]   float8 = '0;
  logic          out_valid8;
  logic [W-1:0]  int_out8;
  logic [3:0]    status8;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   st;
    int           lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   seen = 1'b0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_fixed_converter #(.OUT_W(W), .FRAC_BITS(0)) u_dut (
    .clock100KHz(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .float_in(float_in), .out_valid(out_valid), .out_ready(out_ready),
    .int_out(int_out), .status_out(status_out)
  );

  fpu_fixed_converter #(.OUT_W(W), .FRAC_BITS(8)) u_dut8 (
    .clock100KHz(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .float_in(float8), .out_valid(out_valid8), .out_ready(1'b1),
    .int_out(int_out8), .status_out(status8)
  );

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mk(bit s, int e, int m);
    return {s, 6'(e), 25'(m)};
  endfunction

  // Exact value is sig * 2^(e-56+fb); truncate toward zero, then range-check.
  function automatic exp_t model(logic [31:0] f, int fb);
    exp_t r;
    bit s = f[31];
    int e = int'(f[30:25]);
    logic [127:0] sig = 128'({1'b1, f[24:0]});
    logic [127:0] mag, lim;
    logic [W-1:0] lo;
    bit inex;
    int k = e - 56 + fb;
    r.lat = 2;
    if (e == 0) begin
      r.res = '0; r.st = 4'b0001; return r;
    end
    if (k >= 0) begin
      mag = sig << k; inex = 1'b0;
    end else begin
      mag = sig >> (-k); inex = ((sig & ((128'd1 << (-k)) - 128'd1)) != 0);
    end
    lim = 128'd1 << (W - 1);
    if ((!s && mag >= lim) || (s && mag > lim)) begin
      r.res = s ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      r.st  = 4'b1000;
    end else if (s && mag == lim) begin
      r.res = {1'b1, {(W-1){1'b0}}}; r.st = 4'b0000;
    end else if (mag == 0) begin
      r.res = '0; r.st = 4'b0111;
    end else begin
      lo    = mag[W-1:0];
      r.res = s ? -lo : lo;
      r.st  = {2'b00, inex, 1'b0};
      r.lat = 2 + ((k < 0) ? -k : k);
    end
    return r;
  endfunction

  // Monitor: latency at first sight of out_valid, data on handshake.
  initial forever begin
    exp_t it;
    @(negedge clk);
    if (reset) begin
      seen = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc + 1;
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (q.size() > 0) chk("latency", 64'(cyc - acc_cyc), 64'(q[0].lat));
      end
      if (out_valid && out_ready) begin
        chk("pending_expect", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          it = q.pop_front();
          chk("int_out", 64'(int_out), 64'(it.res));
          chk("status", 64'(status_out), 64'(it.st));
        end
        seen = 1'b0;
      end
    end
  end

  // Random consumer backpressure when enabled.
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(logic [31:0] f);
    int n = 0;
    @(posedge clk); #1;
    q.push_back(model(f, 0));
    in_valid = 1'b1;
    float_in = f;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic send8(logic [31:0] f);
    exp_t e8 = model(f, 8);
    int n = 0;
    @(posedge clk); #1;
    in_valid8 = 1'b1;
    float8 = f;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    while (!out_valid8 && n < 300) begin
      @(negedge clk); n++;
    end
    chk("frac8_valid", 64'(out_valid8), 64'd1);
    chk("frac8_int_out", 64'(int_out8), 64'(e8.res));
    chk("frac8_status", 64'(status8), 64'(e8.st));
  endtask

  initial begin
    exp_t hold;
    logic [31:0] f;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_int_out", 64'(int_out), 64'd0);
    chk("rst_status", 64'(status_out), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed corners.
    send(32'h0000_0000);
    send(mk(0, 31, 0));
    send(mk(0, 31, 1 << 24));
    send(mk(1, 32, 0));
    send(mk(0, 33, 0));
    send(mk(0, 63, 32'h1FF_FFFF));
    send(mk(1, 62, 0));
    send(mk(1, 62, 1));
    send(mk(0, 62, 0));
    send(mk(0, 61, 32'h1FF_FFFF));
    send(mk(0, 1, 1));
    send(32'h8000_0000);
    send(mk(1, 56, 5));
    send(mk(1, 30, 3));
    drain();

    // Random floats with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      f = $urandom();
      if ($urandom_range(0, 3) != 0) f[30:25] = 6'($urandom_range(26, 62));
      send(f);
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Result held while consumer stalls.
    @(posedge clk); #1;
    out_ready = 1'b0;
    f = mk(1, 40, 12345);
    hold = model(f, 0);
    send(f);
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk); n++;
    end
    repeat (10) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_int_out", 64'(int_out), 64'(hold.res));
      chk("hold_status", 64'(status_out), 64'(hold.st));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a long right shift.
    send(mk(0, 31, 0));
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (30) begin
      @(negedge clk);
      chk("postrst_no_valid", 64'(out_valid), 64'd0);
    end
    send(mk(0, 33, 0));
    send(mk(1, 35, 1 << 23));
    drain();

    // Fraction bits: +1 -> 256, +1.5 -> 384, -0.75 -> -192.
    send8(mk(0, 31, 0));
    send8(mk(0, 31, 1 << 24));
    send8(mk(1, 30, 1 << 24));
    send8(mk(0, 20, 7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
